// File: rtl/mgt01_sqrt_reconstruct.sv
// Rebuilds radicand = root^2 + remainder from a sqrt result pair with a serial shift-add squarer.
// States: IDLE accept operands | SQUARE one multiplier bit per cycle | ADD final sum and flags | DONE hold result.
module mgt01_sqrt_reconstruct #(
  parameter int DATA_WIDTH = 48
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH/2-1:0] root_i,
  input  logic [DATA_WIDTH/2:0]   remainder_i,
  output logic [DATA_WIDTH-1:0]   radicand_o,
  output logic                    overflow_o,
  output logic                    invalid_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int ROOT_W     = DATA_WIDTH / 2;
  localparam int REM_W      = ROOT_W + 1;
  localparam int ITERATIONS = ROOT_W;
  localparam int CNT_W      = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQUARE,
    S_ADD,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [ROOT_W-1:0]       mplier_q;
  logic [ROOT_W-1:0]       root_q;
  logic [REM_W-1:0]        rem_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   radicand_q;
  logic                    overflow_q;
  logic                    invalid_q;
  logic                    valid_q;
  logic                    ready_q;

  logic [DATA_WIDTH-1:0]   acc_d;
  logic [DATA_WIDTH:0]     sum_d;
  logic [REM_W-1:0]        root_x2_d;
  logic                    invalid_d;

  // root^2 < 2^DATA_WIDTH, so the partial-product accumulation never wraps
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign sum_d     = {1'b0, acc_q} + {{(DATA_WIDTH - REM_W + 1){1'b0}}, rem_q};
  assign root_x2_d = {root_q, 1'b0};
  assign invalid_d = (rem_q > root_x2_d);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_INIT;
      mcand_q    <= '0;
      mplier_q   <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      radicand_q <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            mcand_q  <= {{(DATA_WIDTH - ROOT_W){1'b0}}, root_i};
            mplier_q <= root_i;
            root_q   <= root_i;
            rem_q    <= remainder_i;
            acc_q    <= '0;
            cnt_q    <= CNT_INIT;
            ready_q  <= 1'b0;
            state_q  <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          radicand_q <= sum_d[DATA_WIDTH-1:0];
          overflow_q <= sum_d[DATA_WIDTH];
          invalid_q  <= invalid_d;
          valid_q    <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign radicand_o = radicand_q;
  assign overflow_o = overflow_q;
  assign invalid_o  = invalid_q;

endmodule

// File: tb/tb_mgt01_sqrt_reconstruct.sv
// Self-checking bench for mgt01_sqrt_reconstruct: directed corner pairs plus randomized pairs
// against an arithmetic model of root^2 + remainder.
module tb_mgt01_sqrt_reconstruct;
  localparam int DW  = 48;
  localparam int RW  = DW / 2;
  localparam int LAT = RW + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clk_en_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [RW-1:0] root_i = '0;
  logic [RW:0]   remainder_i = '0;
  logic [DW-1:0] radicand_o;
  logic          overflow_o;
  logic          invalid_o;
  logic          valid_o;
  logic          ready_i = 1'b1;

  int errors = 0;
  int checks = 0;
  longint unsigned cyc = 0;

  mgt01_sqrt_reconstruct #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .root_i(root_i), .remainder_i(remainder_i),
    .radicand_o(radicand_o), .overflow_o(overflow_o), .invalid_o(invalid_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // valid_o and ready_o must never be high together
  always @(negedge clk_i) begin
    if (!rst_i) begin
      checks++;
      if (valid_o && ready_o) begin
        errors++;
        $display("FAIL handshake_excl t=%0t valid_o=%0b ready_o=%0b required not both 1", $time, valid_o, ready_o);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model(input longint unsigned r, input longint unsigned m,
                                output logic [DW-1:0] rad, output logic ovf, output logic inv);
    longint unsigned s;
    s   = r * r + m;
    rad = s[DW-1:0];
    ovf = s[DW];
    inv = (m > 2 * r);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] r, input logic [RW:0] m, output bit ok);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    ok = ready_o;
    valid_i     = 1'b1;
    root_i      = r;
    remainder_i = m;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (radicand_o !== '0 || overflow_o !== 1'b0 || invalid_o !== 1'b0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state rad=%0h ovf=%0b inv=%0b valid=%0b ready=%0b required 0/0/0/0/1",
               radicand_o, overflow_o, invalid_o, valid_o, ready_o);
    end
  endtask

  task automatic test_zero();
    bit ok;
    int n;
    ready_i = 1'b1;
    issue('0, '0, ok);
    wait_valid(n);
    checks++;
    if (!ok || n !== LAT) begin
      errors++;
      $display("FAIL zero_latency ok=%0b edges=%0d required %0d", ok, n, LAT);
    end
    checks++;
    if (radicand_o !== '0 || overflow_o !== 1'b0 || invalid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_result rad=%0h ovf=%0b inv=%0b required 0/0/0", radicand_o, overflow_o, invalid_o);
    end
    tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_return ready=%0b valid=%0b required 1/0", ready_o, valid_o);
    end
  endtask

  // directed legal/illegal pairs including the width boundaries
  task automatic test_directed();
    logic [RW-1:0] roots [5];
    logic [RW:0]   rems  [5];
    logic [DW-1:0] erad;
    logic          eovf, einv;
    bit ok;
    int n;
    roots = '{24'd5, 24'hFFFFFF, 24'hFFFFFF, 24'd3, 24'd1};
    rems  = '{25'd3, 25'h1FFFFFE, 25'h1FFFFFF, 25'd7, 25'd2};
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      model(longint'(roots[i]), longint'(rems[i]), erad, eovf, einv);
      issue(roots[i], rems[i], ok);
      wait_valid(n);
      checks++;
      if (!ok || n !== LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d] ok=%0b edges=%0d required %0d", i, ok, n, LAT);
      end
      checks++;
      if (radicand_o !== erad || overflow_o !== eovf || invalid_o !== einv) begin
        errors++;
        $display("FAIL directed_result[%0d] rad=%0h ovf=%0b inv=%0b required %0h/%0b/%0b",
                 i, radicand_o, overflow_o, invalid_o, erad, eovf, einv);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    ready_i = 1'b0;
    issue(24'd12, 25'd0, ok);
    wait_valid(n);
    checks++;
    if (!ok || n !== LAT) begin
      errors++;
      $display("FAIL bp_latency ok=%0b edges=%0d required %0d", ok, n, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid_o !== 1'b1 || radicand_o !== 48'd144 || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%0b rad=%0d ready=%0b required 1/144/0", i, valid_o, radicand_o, ready_o);
      end
    end
    clk_en_i = 1'b0;
    ready_i  = 1'b1;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_freeze_done valid=%0b ready=%0b required 1/0", valid_o, ready_o);
    end
    clk_en_i = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || radicand_o !== 48'd144) begin
      errors++;
      $display("FAIL bp_accept ready=%0b valid=%0b rad=%0d required 1/0/144", ready_o, valid_o, radicand_o);
    end
  endtask

  task automatic test_clk_en();
    bit ok;
    int n, total;
    ready_i = 1'b1;
    issue(24'd7, 25'd9, ok);
    total = 0;
    for (int i = 0; i < 5; i++) begin tick(); total++; end
    clk_en_i    = 1'b0;
    valid_i     = 1'b1;
    root_i      = 24'd999;
    remainder_i = 25'd1;
    for (int i = 0; i < 4; i++) begin tick(); total++; end
    clk_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); total++; end
    valid_i = 1'b0;
    wait_valid(n);
    total += n;
    checks++;
    if (!ok || total !== LAT + 4) begin
      errors++;
      $display("FAIL clken_latency ok=%0b edges=%0d required %0d", ok, total, LAT + 4);
    end
    checks++;
    if (radicand_o !== 48'd58 || invalid_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL clken_result rad=%0d inv=%0b ovf=%0b required 58/0/0", radicand_o, invalid_o, overflow_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    ready_i = 1'b1;
    issue(24'd40, 25'd0, ok);
    for (int i = 0; i < 6; i++) tick();
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || radicand_o !== '0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset valid=%0b rad=%0h ready=%0b required 0/0/1", valid_o, radicand_o, ready_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset valid=%0b ready=%0b required 0/1", valid_o, ready_o);
    end
    issue(24'd100, 25'd50, ok);
    wait_valid(n);
    checks++;
    if (!ok || n !== LAT || radicand_o !== 48'd10050 || invalid_o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op ok=%0b edges=%0d rad=%0d inv=%0b required %0d/10050/0",
               ok, n, radicand_o, invalid_o, LAT);
    end
    tick();
  endtask

  task automatic test_random();
    logic [RW-1:0] r;
    logic [RW:0]   m;
    logic [DW-1:0] erad;
    logic          eovf, einv;
    bit ok;
    int n, hold;
    for (int k = 0; k < 25; k++) begin
      r = RW'($urandom);
      if ($urandom_range(0, 1) == 1) m = (RW+1)'($urandom_range(0, 2 * int'(r)));
      else                           m = (RW+1)'($urandom);
      model(longint'(r), longint'(m), erad, eovf, einv);
      hold    = $urandom_range(0, 3);
      ready_i = (hold == 0);
      issue(r, m, ok);
      wait_valid(n);
      checks++;
      if (!ok || n !== LAT) begin
        errors++;
        $display("FAIL rand_latency[%0d] ok=%0b edges=%0d required %0d", k, ok, n, LAT);
      end
      for (int h = 0; h < hold; h++) tick();
      checks++;
      if (valid_o !== 1'b1 || radicand_o !== erad || overflow_o !== eovf || invalid_o !== einv) begin
        errors++;
        $display("FAIL rand_result[%0d] root=%0h rem=%0h valid=%0b rad=%0h ovf=%0b inv=%0b required 1/%0h/%0b/%0b",
                 k, r, m, valid_o, radicand_o, overflow_o, invalid_o, erad, eovf, einv);
      end
      ready_i = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    longint unsigned t0, t1;
    bit ok;
    int n;
    ready_i = 1'b1;
    issue(24'd9, 25'd1, ok);
    t0 = cyc;
    wait_valid(n);
    tick();
    issue(24'd11, 25'd2, ok);
    t1 = cyc;
    checks++;
    if (t1 - t0 !== longint'(LAT + 2)) begin
      errors++;
      $display("FAIL b2b_interval got=%0d required %0d", t1 - t0, LAT + 2);
    end
    wait_valid(n);
    checks++;
    if (n !== LAT || radicand_o !== 48'd123) begin
      errors++;
      $display("FAIL b2b_result edges=%0d rad=%0d required %0d/123", n, radicand_o, LAT);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_backpressure();
    test_clk_en();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mgt01_sqrt_reconstruct.md
Name:
mgt01_sqrt_reconstruct

Overview:
- Iterative inverse of the non-restoring square-root unit: rebuilds radicand = root² + remainder from a (root, remainder) pair.
- Flags pairs that are not a legal square-root result.
- Sits beside the sqrt unit in the arithmetic modules. It serves as an in-line self-check for integer and FP sqrt, and as a squaring engine for the FPU.
- Sequential shift-add squarer (one multiplier bit per cycle), then a final add stage, with valid/ready handshakes on both ends.

Parameters:
- DATA_WIDTH, 48, radicand width; must be even and ≥ 4. Root width is DATA_WIDTH/2; remainder width is DATA_WIDTH/2+1.
- ITERATIONS, DATA_WIDTH/2, localparam: number of squaring cycles.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- clk_en_i  in  1  clock enable; when low, all state and registers hold
- valid_i  in  1  input operands valid
- ready_o  out  1  block can accept operands (high only in IDLE)
- root_i  in  DATA_WIDTH/2  unsigned root
- remainder_i  in  DATA_WIDTH/2+1  unsigned remainder (already restored, non-negative)
- radicand_o  out  DATA_WIDTH  reconstructed radicand, low DATA_WIDTH bits of root² + remainder
- overflow_o  out  1  carry out of bit DATA_WIDTH-1 of the final sum
- invalid_o  out  1  remainder_i > 2·root_i (not a legal sqrt pair)
- valid_o  out  1  result valid; held until accepted
- ready_i  in  1  downstream accepts the result

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE, counter=ITERATIONS-1, all data registers=0. Output values: radicand_o=0, overflow_o=0, invalid_o=0, valid_o=0, ready_o=1 after release.
- All register updates, including state transitions, require clk_en_i=1. With clk_en_i=0 everything freezes, including a pending DONE result and its valid_o.
- FSM states: IDLE, SQUARE, ADD, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i & clk_en_i: latch mcand = zero-extended root_i (DATA_WIDTH bits), mplier = root_i, rem = remainder_i; clear acc; counter=ITERATIONS-1; go to SQUARE.
  - Without valid_i: stay in IDLE.
- SQUARE, one cycle per iteration:
  - If mplier[0], then acc += mcand. The addition is modulo 2^DATA_WIDTH and cannot overflow because root² < 2^DATA_WIDTH.
  - Then mcand <<= 1, mplier >>= 1, counter -= 1.
  - When counter==0 during a SQUARE cycle, go to ADD after that cycle. SQUARE lasts exactly ITERATIONS cycles.
- ADD, 1 cycle:
  - sum = acc + zero-extended rem, computed DATA_WIDTH+1 bits wide.
  - Registers: radicand_o=sum[DATA_WIDTH-1:0], overflow_o=sum[DATA_WIDTH], invalid_o=(rem > {mcand_orig,1'b0}), where the compare uses the latched root ×2 at DATA_WIDTH/2+1 bits.
  - Go to DONE.
- DONE:
  - valid_o=1.
  - Results and flags are stable; they hold until the next ADD overwrites them, including while in IDLE.
  - ready_i & clk_en_i: go to IDLE. Otherwise stay in DONE.
- Latency: operands accepted on edge E; valid_o rises after edge E+ITERATIONS+1. For the default width that is 25 edges.
- Throughput: the next operands can be accepted the cycle after the DONE handshake. Minimum issue interval is ITERATIONS+3 cycles.
- Input hold rule: valid_i/operands are sampled only in IDLE. Changes while busy are ignored; no requirement to hold them beyond acceptance.
- Legal pairs (remainder ≤ 2·root) never overflow, since root²+2·root = (root+1)²-1 < 2^DATA_WIDTH. Therefore overflow_o=1 implies invalid_o=1.
- Reset mid-operation: asserting rst_i in any state aborts immediately to IDLE with all outputs cleared. No stale valid_o after release.
- valid_o and ready_o are never high together.

Test Plan:
1. root_i=0, remainder_i=0, ready_i=1 → valid_o after 25 edges, radicand_o=0, overflow_o=0, invalid_o=0; ready_o back to 1 next cycle.
2. root_i=5, remainder_i=3 → radicand_o=28, invalid_o=0. Then root_i=0xFFFFFF, remainder_i=0x1FFFFFE → radicand_o=0xFFFF_FFFF_FFFF, overflow_o=0, invalid_o=0.
3. root_i=0xFFFFFF, remainder_i=0x1FFFFFF → radicand_o=0, overflow_o=1, invalid_o=1. Separately, root_i=3, remainder_i=7 → radicand_o=16, invalid_o=1, overflow_o=0.
4. Hold ready_i=0 for 10 cycles after valid_o rises (root_i=12, remainder_i=0) → valid_o stays high and radicand_o=144 stays stable; accept on ready_i=1, then ready_o=1.
5. Pulse clk_en_i low for 4 cycles in mid-SQUARE, and drive new valid_i/root_i while busy → latency extends by exactly 4 cycles, and the result is the original pair's value.
6. Assert rst_i asynchronously (between clock edges) during SQUARE → valid_o=0, radicand_o=0, ready_o=1 immediately. A new operation (root_i=100, remainder_i=50) → radicand_o=10050.
